// File: rtl/mem_io_handshake_pkg.sv
// Shared types and defaults for the memory-stage I/O handshake controller.
// The optional timeout is enabled by defining MEM_IO_TIMEOUT_EN.
package mem_io_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IN  = 2'd1,
        WAIT_OUT = 2'd2,
        DONE     = 2'd3
    } io_state_t;

    localparam int DATA_WIDTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    function automatic int tmo_ctr_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    localparam int TMO_CTR_W = tmo_ctr_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/mem_io_handshake_timeout_ctr.sv
// Wait-state timeout counter: load clears, en counts, tc flags TIMEOUT_CYCLES-1.
// Only instantiated when MEM_IO_TIMEOUT_EN is defined.
module mem_io_timeout_ctr
    import mem_io_handshake_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int W = tmo_ctr_w(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    cnt <= '0;
        else if (load) cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_io_handshake.sv
// Memory-stage IN/OUT controller: turns pipeline strobes into a valid/ready port
// handshake and stalls until done. Define MEM_IO_TIMEOUT_EN for bounded waits.
module mem_io_handshake
    import mem_io_handshake_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_en,
    input  logic                  io_rd,
    input  logic                  io_wr,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic [DATA_WIDTH-1:0] port_in,
    input  logic                  port_in_valid,
    input  logic                  port_out_ready,
    output logic [DATA_WIDTH-1:0] port_out,
    output logic                  port_out_valid,
    output logic                  port_in_ack,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_data_valid,
    output logic                  stall,
    output logic                  io_err
);
    io_state_t state, state_nxt;
    logic req, rd_req, wr_req, illegal, in_hs, out_hs, waiting, tmo;

    assign req     = io_en & (io_rd | io_wr);
    assign rd_req  = io_en & io_rd;
    assign wr_req  = io_en & io_wr & ~io_rd;
    assign illegal = io_en & io_rd & io_wr;
    assign in_hs   = (state == WAIT_IN) & port_in_valid;
    assign out_hs  = (state == WAIT_OUT) & port_out_ready;
    assign waiting = (state == WAIT_IN) | (state == WAIT_OUT);

`ifdef MEM_IO_TIMEOUT_EN
    logic tc;

    mem_io_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk   (clk),
        .reset (reset),
        .load  (state == IDLE),
        .en    (waiting),
        .tc    (tc)
    );

    assign tmo = tc & waiting;
`else
    assign tmo = 1'b0;
`endif

    assign stall = ((state == IDLE) & req) | waiting;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (rd_req)      state_nxt = WAIT_IN;
                else if (wr_req) state_nxt = WAIT_OUT;
            end
            WAIT_IN:  if (in_hs | tmo)  state_nxt = DONE;
            WAIT_OUT: if (out_hs | tmo) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            port_out       <= '0;
            port_out_valid <= 1'b0;
            port_in_ack    <= 1'b0;
            in_data        <= '0;
            in_data_valid  <= 1'b0;
            io_err         <= 1'b0;
        end else begin
            state         <= state_nxt;
            port_in_ack   <= 1'b0;
            in_data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (illegal) io_err <= 1'b1;
                    if (wr_req) begin
                        port_out       <= result;
                        port_out_valid <= 1'b1;
                    end
                end
                WAIT_IN: begin
                    // A real handshake beats a coincident timeout.
                    if (in_hs) begin
                        in_data       <= port_in;
                        in_data_valid <= 1'b1;
                        port_in_ack   <= 1'b1;
                    end else if (tmo) begin
                        in_data       <= '0;
                        in_data_valid <= 1'b1;
                        io_err        <= 1'b1;
                    end
                end
                WAIT_OUT: begin
                    if (out_hs | tmo) port_out_valid <= 1'b0;
                    if (!out_hs && tmo) io_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_handshake.sv
// Directed bench for mem_io_handshake; the timeout case runs when MEM_IO_TIMEOUT_EN
// is defined (DUT built with TIMEOUT_CYCLES=8).
module tb_mem_io_handshake;
    logic        clk = 1'b0;
    logic        reset;
    logic        io_en, io_rd, io_wr;
    logic [15:0] result, port_in;
    logic        port_in_valid, port_out_ready;
    logic [15:0] port_out, in_data;
    logic        port_out_valid, port_in_ack, in_data_valid, stall, io_err;

    int n_chk = 0;
    int n_err = 0;

    mem_io_handshake #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_en          (io_en),
        .io_rd          (io_rd),
        .io_wr          (io_wr),
        .result         (result),
        .port_in        (port_in),
        .port_in_valid  (port_in_valid),
        .port_out_ready (port_out_ready),
        .port_out       (port_out),
        .port_out_valid (port_out_valid),
        .port_in_ack    (port_in_ack),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .stall          (stall),
        .io_err         (io_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, act, exp);
        end
    endtask

    // Issue one request at a negedge and hold it until the DONE cycle (stall low).
    // port_out_ready rises on cycle index rdy_at counted from the request cycle.
    task automatic run_io(input logic rd, input logic wr, input int rdy_at,
                          output int stalls, output int acks, output int idvs, output int povs);
        stalls = 0; acks = 0; idvs = 0; povs = 0;
        @(negedge clk);
        io_en = 1'b1; io_rd = rd; io_wr = wr;
        for (int i = 0; i < 40; i++) begin
            port_out_ready = (i >= rdy_at);
            #1;
            acks += int'(port_in_ack);
            idvs += int'(in_data_valid);
            povs += int'(port_out_valid);
            if (!stall) break;
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic idle_cycle(output int pulses);
        @(negedge clk);
        io_en = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
        #1;
        pulses = int'(port_in_ack) + int'(in_data_valid) + int'(stall);
    endtask

    int s, a, d, p, q;

    initial begin
        reset = 1'b0; io_en = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
        result = '0; port_in = '0; port_in_valid = 1'b0; port_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_port_out", 32'(port_out), 32'h0);
        chk("rst_pov", 32'(port_out_valid), 32'h0);
        chk("rst_in_data", 32'(in_data), 32'h0);
        chk("rst_pulses", 32'(port_in_ack | in_data_valid), 32'h0);
        chk("rst_err", 32'(io_err), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        @(negedge clk); reset = 1'b1;

        // Illegal rd+wr: read wins, write dropped, error sticky.
        result = 16'h00FF; port_in = 16'h0A0A; port_in_valid = 1'b1;
        run_io(1'b1, 1'b1, 0, s, a, d, p);
        chk("ill_stalls", 32'(s), 32'd2);
        chk("ill_ack", 32'(a), 32'd1);
        chk("ill_in_data", 32'(in_data), 32'h0A0A);
        idle_cycle(q);
        chk("ill_idle", 32'(q), 32'd0);
        chk("ill_port_out", 32'(port_out), 32'h0);
        chk("ill_pov", 32'(p), 32'd0);
        chk("ill_err", 32'(io_err), 32'h1);
        repeat (3) @(negedge clk);
        #1 chk("ill_err_sticky", 32'(io_err), 32'h1);

        // Reset mid-transfer during WAIT_OUT.
        @(negedge clk);
        result = 16'h5555; port_out_ready = 1'b0; port_in_valid = 1'b0;
        io_en = 1'b1; io_wr = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("mid_pov_pre", 32'(port_out_valid), 32'h1);
        reset = 1'b0; io_en = 1'b0; io_wr = 1'b0;
        #1;
        chk("mid_pov", 32'(port_out_valid), 32'h0);
        chk("mid_port_out", 32'(port_out), 32'h0);
        chk("mid_err", 32'(io_err), 32'h0);
        chk("mid_stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b1; port_out_ready = 1'b1; port_in_valid = 1'b1;
        q = 0;
        repeat (4) begin
            @(negedge clk); #1;
            q += int'(port_in_ack) + int'(in_data_valid) + int'(port_out_valid) + int'(stall);
        end
        chk("mid_no_activity", 32'(q), 32'd0);

        // IN with the device already valid.
        port_in = 16'hBEEF; port_in_valid = 1'b1;
        run_io(1'b1, 1'b0, 0, s, a, d, p);
        chk("in_stalls", 32'(s), 32'd2);
        chk("in_ack", 32'(a), 32'd1);
        chk("in_idv", 32'(d), 32'd1);
        chk("in_data", 32'(in_data), 32'hBEEF);
        idle_cycle(q);
        chk("in_idle", 32'(q), 32'd0);

        // OUT with 5 cycles of backpressure; stray port_in_valid must be ignored.
        result = 16'h1234; port_in = 16'h7777; port_in_valid = 1'b1;
        run_io(1'b0, 1'b1, 6, s, a, d, p);
        chk("out_stalls", 32'(s), 32'd7);
        chk("out_pov_cycles", 32'(p), 32'd6);
        chk("out_no_ack", 32'(a + d), 32'd0);
        idle_cycle(q);
        chk("out_idle", 32'(q), 32'd0);
        chk("out_port_out", 32'(port_out), 32'h1234);
        chk("out_in_data_kept", 32'(in_data), 32'hBEEF);
        chk("out_err", 32'(io_err), 32'h0);

        // Back-to-back OUT then IN; lingering io_en in DONE is ignored.
        result = 16'hABCD; port_in = 16'hC0DE; port_in_valid = 1'b1;
        run_io(1'b0, 1'b1, 0, s, a, d, p);
        chk("b2b_out_stalls", 32'(s), 32'd2);
        chk("b2b_port_out", 32'(port_out), 32'hABCD);
        result = 16'h9999;
        run_io(1'b1, 1'b0, 0, s, a, d, p);
        chk("b2b_in_stalls", 32'(s), 32'd2);
        chk("b2b_in_ack", 32'(a), 32'd1);
        chk("b2b_in_pov", 32'(p), 32'd0);
        chk("b2b_in_data", 32'(in_data), 32'hC0DE);
        idle_cycle(q);
        chk("b2b_idle", 32'(q), 32'd0);
        chk("b2b_port_out_kept", 32'(port_out), 32'hABCD);

`ifdef MEM_IO_TIMEOUT_EN
        // IN timeout: device never valid; 1 IDLE cycle + 8 WAIT_IN cycles of stall.
        port_in = 16'hDEAD; port_in_valid = 1'b0;
        chk("tmo_err_pre", 32'(io_err), 32'h0);
        run_io(1'b1, 1'b0, 0, s, a, d, p);
        chk("tmo_stalls", 32'(s), 32'd9);
        chk("tmo_no_ack", 32'(a), 32'd0);
        chk("tmo_idv", 32'(d), 32'd1);
        chk("tmo_in_data", 32'(in_data), 32'h0);
        chk("tmo_err", 32'(io_err), 32'h1);
        idle_cycle(q);
        chk("tmo_idle", 32'(q), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_io_handshake.md
Name: mem_io_handshake

Overview:
- Memory-stage I/O access controller, directly upstream of the I/O port latch block.
- Converts pipeline IN/OUT requests (enable/read/write strobes plus ALU result) into a valid/ready handshake with an external port device.
- Stalls the pipeline until the transfer completes.
- Delivers captured input data, with a one-cycle valid, toward write-back and the port latch.

Parameters:
DATA_WIDTH, 16, width of the port data and result buses
TIMEOUT_CYCLES, 64, cycles spent in a wait state before forced completion (used only when the optional feature is compiled in; must be >= 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
io_en  input  1  I/O instruction present in the memory stage
io_rd  input  1  IN instruction (read the port)
io_wr  input  1  OUT instruction (write the port)
result  input  DATA_WIDTH  value to output on OUT
port_in  input  DATA_WIDTH  external input pins
port_in_valid  input  1  external device has data on port_in
port_out_ready  input  1  external device accepts port_out
port_out  output  DATA_WIDTH  registered output data, held after transfer
port_out_valid  output  1  port_out offer pending
port_in_ack  output  1  one-cycle pulse: input word consumed
in_data  output  DATA_WIDTH  captured input word
in_data_valid  output  1  one-cycle pulse: in_data is new
stall  output  1  freeze the PC and the upstream pipeline registers
io_err  output  1  sticky timeout / illegal-request flag

Behaviour:
- Reset: clk is the single clock; reset is asynchronous, active-low.
  - While reset = 0: state = IDLE; port_out, in_data and the timeout counter = 0; port_out_valid, port_in_ack, in_data_valid and io_err = 0.
  - Asserting reset mid-transfer aborts the transfer immediately. No ack is issued.
- Request decode: req = io_en & (io_rd | io_wr). Both io_rd and io_wr set means read wins, the write is dropped, and io_err is set.
- stall is combinational: (IDLE & req) | WAIT_IN | WAIT_OUT. stall is 0 in DONE and during reset unless req is present.
- FSM states: IDLE, WAIT_IN, WAIT_OUT, DONE (2-bit encoding).
  - IDLE, read request: go to WAIT_IN.
  - IDLE, write request: port_out <= result, port_out_valid <= 1, go to WAIT_OUT.
  - IDLE, no request: stay.
  - WAIT_IN, port_in_valid = 1: in_data <= port_in, go to DONE. port_in_ack and in_data_valid are registered and both high for exactly the DONE cycle.
  - WAIT_OUT, port_out_ready = 1 (port_out_valid is 1): port_out_valid <= 0, go to DONE. port_out keeps its value until the next OUT.
  - DONE: unconditionally go to IDLE. The io_en still present from the retiring instruction in this cycle is ignored.
- Latency:
  - Minimum stall is 2 cycles for both IN and OUT, when the device is already valid/ready.
  - Completion is observed one cycle after the handshake cycle.
- port_in_valid or port_out_ready asserted outside the matching wait state is ignored.
- port_out_valid never drops without port_out_ready, except on timeout or reset.
- io_err clears only on reset.

Optional Feature:
- Macro: MEM_IO_TIMEOUT_EN.
- Defined:
  - The counter resets on entry to WAIT_IN or WAIT_OUT and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES-1 with no handshake, go to DONE and set io_err.
  - WAIT_IN timeout: in_data <= 0, in_data_valid still pulses, port_in_ack stays 0.
  - WAIT_OUT timeout: port_out_valid <= 0.
  - A handshake in the same cycle as the timeout wins; no error is flagged.
- Undefined: no counter exists; waits are unbounded; io_err is set only by an illegal request.

Decomposition:
- Shared package holds: state typedef/encoding (IDLE=0, WAIT_IN=1, WAIT_OUT=2, DONE=3), DATA_WIDTH default, TIMEOUT_CYCLES default, and the counter-width constant derived by clog2.
- One natural sub-module: mem_io_timeout_ctr (load/enable/terminal-count).
  - Instantiated only under MEM_IO_TIMEOUT_EN.

Test Plan:
- IN, device ready: port_in=16'hBEEF and port_in_valid=1 before the request.
  - Expect stall for 2 cycles, in_data=16'hBEEF with in_data_valid and port_in_ack pulsing together once.
- OUT with backpressure: result=16'h1234, port_out_ready held low 5 cycles then high.
  - Expect port_out=16'h1234 and valid high for 6 cycles, stall for 7 cycles.
  - port_out still 16'h1234 afterwards.
- Illegal request: io_rd=io_wr=1, result=16'h00FF, port_in=16'h0A0A.
  - Expect read performed, port_out unchanged at 0, io_err=1 and sticky.
- Reset mid-transfer: reset low during WAIT_OUT.
  - Expect immediate port_out_valid=0, port_out=0, state IDLE.
  - No ack pulses after release.
- Timeout (MEM_IO_TIMEOUT_EN, TIMEOUT_CYCLES=8): IN with port_in_valid never asserted.
  - Expect stall to end after the count, in_data=0, in_data_valid pulse, io_err=1, no port_in_ack.
- Back-to-back: OUT then IN in consecutive instructions.
  - Expect the DONE cycle to ignore the lingering io_en.
  - Second request accepted in the following IDLE cycle; no double transfer.
